// File: rtl/eth_pkt_gen_if.sv
// rtl/eth_pkt_gen_if.sv - register bus and TSE TX FIFO stream bundle for the packet generator
interface eth_pkt_gen_if;
  logic [2:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  logic [31:0] tx_data;
  logic        tx_wren;
  logic        tx_sop;
  logic        tx_eop;
  logic [1:0]  tx_mod;
  logic        tx_err;
  logic        tx_rdy;

  modport master (
    input  address, write, read, writedata, tx_rdy,
    output readdata, tx_data, tx_wren, tx_sop, tx_eop, tx_mod, tx_err
  );

  modport slave (
    output address, write, read, writedata, tx_rdy,
    input  readdata, tx_data, tx_wren, tx_sop, tx_eop, tx_mod, tx_err
  );
endinterface

// File: rtl/eth_pkt_gen.sv
// rtl/eth_pkt_gen.sv - register-programmed Ethernet frame generator feeding the MAC TX FIFO
module eth_pkt_gen #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic clk,
  input  logic reset,
  eth_pkt_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, HDR, PAY, IPG} state_t;

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  logic [31:0]  number_packet;
  logic [31:0]  packet_tx_count;
  logic [31:0]  count_inc;
  logic [15:0]  pkt_length;
  logic [47:0]  dst_mac;
  logic [47:0]  src_mac;
  logic         start_q;
  logic         stop;
  logic         done;
  logic         busy;

  state_t       state;
  state_t       state_n;
  logic [15:0]  beat;
  logic [15:0]  len_l;
  logic [15:0]  len_c;
  logic [15:0]  last_beat;
  logic [47:0]  dst_l;
  logic [47:0]  src_l;
  logic [111:0] hdr;
  logic [31:0]  word;
  logic [17:0]  ofs;
  logic [7:0]   byte_v;
  logic         eop;

  logic latch, beat_clr, beat_inc, clr_stat, set_done, set_busy, clr_busy, inc_count, wren;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      number_packet <= '0;
      pkt_length    <= '0;
      dst_mac       <= '0;
      src_mac       <= '0;
      start_q       <= 1'b0;
      stop          <= 1'b0;
    end else begin
      start_q <= bus.write && (bus.address == 3'd7) && bus.writedata[0];
      if (bus.write) begin
        case (bus.address)
          3'd0:    number_packet  <= bus.writedata;
          3'd1:    pkt_length     <= bus.writedata[15:0];
          3'd2:    dst_mac[31:0]  <= bus.writedata;
          3'd3:    dst_mac[47:32] <= bus.writedata[15:0];
          3'd4:    src_mac[31:0]  <= bus.writedata;
          3'd5:    src_mac[47:32] <= bus.writedata[15:0];
          3'd7:    stop           <= bus.writedata[1];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.read) begin
      case (bus.address)
        3'd0:    bus.readdata = number_packet;
        3'd1:    bus.readdata = {16'h0000, pkt_length};
        3'd2:    bus.readdata = dst_mac[31:0];
        3'd3:    bus.readdata = {16'h0000, dst_mac[47:32]};
        3'd4:    bus.readdata = src_mac[31:0];
        3'd5:    bus.readdata = {16'h0000, src_mac[47:32]};
        3'd6:    bus.readdata = packet_tx_count;
        default: bus.readdata = {28'h0, busy, done, stop, start_q};
      endcase
    end
  end

  assign len_c     = (pkt_length < MIN_L) ? MIN_L : (pkt_length > MAX_L) ? MAX_L : pkt_length;
  assign last_beat = ((len_l + 16'd3) >> 2) - 16'd1;
  assign count_inc = packet_tx_count + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    latch     = 1'b0;
    beat_clr  = 1'b0;
    beat_inc  = 1'b0;
    clr_stat  = 1'b0;
    set_done  = 1'b0;
    set_busy  = 1'b0;
    clr_busy  = 1'b0;
    inc_count = 1'b0;
    wren      = 1'b0;
    case (state)
      IDLE: begin
        if (start_q && !busy) begin
          clr_stat = 1'b1;
          if (number_packet == 32'd0) begin
            set_done = 1'b1;
          end else begin
            set_busy = 1'b1;
            latch    = 1'b1;
            beat_clr = 1'b1;
            state_n  = HDR;
          end
        end
      end
      HDR: begin
        wren = 1'b1;
        if (bus.tx_rdy) begin
          beat_inc = 1'b1;
          if (beat == 16'd3) state_n = PAY;
        end
      end
      PAY: begin
        wren = 1'b1;
        if (bus.tx_rdy) begin
          if (beat == last_beat) state_n = IPG;
          else                   beat_inc = 1'b1;
        end
      end
      IPG: begin
        inc_count = 1'b1;
        if ((count_inc == number_packet) || stop) begin
          set_done = 1'b1;
          clr_busy = 1'b1;
          state_n  = IDLE;
        end else begin
          latch    = 1'b1;
          beat_clr = 1'b1;
          state_n  = HDR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Length and MACs are snapshotted at frame start so register writes never tear a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat            <= '0;
      len_l           <= '0;
      dst_l           <= '0;
      src_l           <= '0;
      packet_tx_count <= '0;
      done            <= 1'b0;
      busy            <= 1'b0;
    end else begin
      if (beat_clr)      beat <= '0;
      else if (beat_inc) beat <= beat + 16'd1;
      if (latch) begin
        len_l <= len_c;
        dst_l <= dst_mac;
        src_l <= src_mac;
      end
      if (clr_stat)       packet_tx_count <= '0;
      else if (inc_count) packet_tx_count <= count_inc;
      if (set_done)      done <= 1'b1;
      else if (clr_stat) done <= 1'b0;
      if (set_busy)      busy <= 1'b1;
      else if (clr_busy) busy <= 1'b0;
    end
  end

  assign hdr = {dst_l, src_l, len_l - 16'd14};

  // Each byte lane is derived from its absolute frame offset: header, k-pattern payload, or pad.
  always_comb begin
    word   = '0;
    ofs    = '0;
    byte_v = '0;
    for (int i = 0; i < 4; i++) begin
      ofs = {beat, 2'b00} + 18'(i);
      if (ofs >= {2'b00, len_l})   byte_v = 8'h00;
      else if (ofs < 18'd14)       byte_v = hdr[8*(13 - int'(ofs[3:0])) +: 8];
      else                         byte_v = 8'(ofs - 18'd14);
      word[8*(3-i) +: 8] = byte_v;
    end
  end

  assign eop         = (state == PAY) && (beat == last_beat);
  assign bus.tx_wren = wren;
  assign bus.tx_sop  = (state == HDR) && (beat == 16'd0);
  assign bus.tx_eop  = eop;
  assign bus.tx_mod  = eop ? (2'd0 - len_l[1:0]) : 2'd0;
  assign bus.tx_data = wren ? word : 32'h0;
  assign bus.tx_err  = 1'b0;
endmodule

// File: tb/tb_eth_pkt_gen.sv
// tb/tb_eth_pkt_gen.sv - directed table-driven bench for eth_pkt_gen
module tb_eth_pkt_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  eth_pkt_gen_if bus();
  eth_pkt_gen #(.MIN_LEN(60), .MAX_LEN(1514)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [15:0] len_in;
    int          eff_len;
    int          beats;
    logic [1:0]  mod;
    logic [31:0] last;
    logic [31:0] w3;
  } vec_t;

  vec_t        vt [8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [47:0] dst_v = 48'h001122334455;
  logic [47:0] src_v = 48'h66778899AABB;

  int          frames, sop_cnt, eop_cnt, good_frames, bad_frames;
  int          hold_err, bubble_err, gap_bad, last_beats, timeout;
  logic [1:0]  last_mod;
  logic [31:0] last_data;
  logic [31:0] wbuf [5];
  logic        first_sop, seen_wren;
  logic [31:0] rd;
  logic        any_wren;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    #1 d = bus.readdata;
    bus.read = 1'b0;
  endtask

  task automatic program_macs();
    reg_write(3'd2, dst_v[31:0]);
    reg_write(3'd3, {16'h0, dst_v[47:32]});
    reg_write(3'd4, src_v[31:0]);
    reg_write(3'd5, {16'h0, src_v[47:32]});
  endtask

  function automatic logic [7:0] exp_byte(input int o, input int len);
    logic [111:0] h;
    logic [15:0]  lt;
    lt = 16'(len - 14);
    h  = {dst_v, src_v, lt};
    if (o >= len) return 8'h00;
    if (o < 14)   return h[8*(13-o) +: 8];
    return 8'(o - 14);
  endfunction

  // Sink with optional random back-pressure; checks framing, hold-while-stalled and the 1-cycle gap.
  task automatic collect(input int nfr, input int rdy_mode, input int eff_len, input int stop_frame, input int budget);
    int cyc, gap, b, ferr, exp_beats;
    logic rdy, prev_stall, in_frame;
    logic [36:0] prev_v, cur_v;
    frames = 0; sop_cnt = 0; eop_cnt = 0; good_frames = 0; bad_frames = 0;
    hold_err = 0; bubble_err = 0; gap_bad = 0; last_beats = 0; timeout = 0;
    last_mod = 0; last_data = 0; first_sop = 0; seen_wren = 0;
    for (int i = 0; i < 5; i++) wbuf[i] = 32'h0;
    exp_beats = (eff_len + 3) / 4;
    cyc = 0; gap = 0; b = 0; ferr = 0; prev_stall = 0; in_frame = 0; prev_v = '0;
    while (frames < nfr && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.write = 1'b0;
      rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.tx_rdy = rdy;
      cur_v = {bus.tx_wren, bus.tx_sop, bus.tx_eop, bus.tx_mod, bus.tx_data};
      if (prev_stall && cur_v !== prev_v) hold_err++;
      if (in_frame && !bus.tx_wren) bubble_err++;
      if (!bus.tx_wren) gap++;
      if (bus.tx_wren && !seen_wren) begin
        seen_wren = 1'b1;
        first_sop = bus.tx_sop;
      end
      if (bus.tx_wren && rdy) begin
        if (bus.tx_sop) begin
          if (in_frame) bubble_err++;
          if (sop_cnt > 0 && gap != 1) gap_bad++;
          sop_cnt++;
          in_frame = 1'b1; b = 0; ferr = 0;
          if (sop_cnt == stop_frame) begin
            bus.address = 3'd7; bus.writedata = 32'h2; bus.write = 1'b1;
          end
        end
        if (in_frame) begin
          if (b < 5) wbuf[b] = bus.tx_data;
          for (int i = 0; i < 4; i++)
            if (bus.tx_data[8*(3-i) +: 8] !== exp_byte(4*b + i, eff_len)) ferr++;
          if (!bus.tx_eop && bus.tx_mod != 2'd0) ferr++;
          b++;
          if (bus.tx_eop) begin
            eop_cnt++; frames++;
            last_beats = b; last_mod = bus.tx_mod; last_data = bus.tx_data;
            if (ferr == 0 && b == exp_beats) good_frames++;
            else                             bad_frames++;
            in_frame = 1'b0; gap = 0;
          end
        end
      end
      prev_stall = bus.tx_wren && !rdy;
      prev_v     = cur_v;
    end
    bus.write = 1'b0;
    if (frames < nfr) timeout = 1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'd64,   64,   16,  2'd0, 32'h2E2F3031, 32'h00320001};
    vt[1] = '{16'd61,   61,   16,  2'd3, 32'h2E000000, 32'h002F0001};
    vt[2] = '{16'd10,   60,   15,  2'd0, 32'h2A2B2C2D, 32'h002E0001};
    vt[3] = '{16'd2000, 1514, 379, 2'd2, 32'hDADB0000, 32'h05DC0001};
    vt[4] = '{16'd62,   62,   16,  2'd2, 32'h2E2F0000, 32'h00300001};
    vt[5] = '{16'd63,   63,   16,  2'd1, 32'h2E2F3000, 32'h00310001};
    vt[6] = '{16'd65,   65,   17,  2'd3, 32'h32000000, 32'h00330001};
    vt[7] = '{16'd1513, 1513, 379, 2'd3, 32'hDA000000, 32'h05DB0001};

    bus.address = 3'd0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = 32'h0; bus.tx_rdy = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'h0, bus.tx_wren, bus.tx_sop, bus.tx_eop, bus.tx_mod, bus.tx_err}, 32'h0);
    check("reset_tx_data", bus.tx_data, 32'h0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      reg_read(3'(a), rd);
      check($sformatf("reset_reg%0d", a), rd, 32'h0);
    end

    program_macs();
    for (int v = 0; v < 8; v++) begin
      reg_write(3'd0, 32'd1);
      reg_write(3'd1, {16'h0, vt[v].len_in});
      reg_write(3'd7, 32'h1);
      collect(1, 0, vt[v].eff_len, 0, 2000);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_beats", v), 32'(last_beats), 32'(vt[v].beats));
      check($sformatf("v%0d_mod", v), {30'h0, last_mod}, {30'h0, vt[v].mod});
      check($sformatf("v%0d_last", v), last_data, vt[v].last);
      check($sformatf("v%0d_w0", v), wbuf[0], 32'h00112233);
      check($sformatf("v%0d_w1", v), wbuf[1], 32'h44556677);
      check($sformatf("v%0d_w2", v), wbuf[2], 32'h8899AABB);
      check($sformatf("v%0d_w3", v), wbuf[3], vt[v].w3);
      check($sformatf("v%0d_w4", v), wbuf[4], 32'h02030405);
      check($sformatf("v%0d_good", v), 32'(good_frames), 32'd1);
      reg_read(3'd7, rd);
      check($sformatf("v%0d_ctrl", v), rd, 32'h4);
      reg_read(3'd6, rd);
      check($sformatf("v%0d_count", v), rd, 32'd1);
    end

    reg_write(3'd0, 32'd3);
    reg_write(3'd1, 32'd64);
    reg_write(3'd7, 32'h1);
    collect(3, 1, 64, 0, 2000);
    repeat (3) @(negedge clk);
    check("bp_timeout", 32'(timeout), 32'd0);
    check("bp_sop", 32'(sop_cnt), 32'd3);
    check("bp_eop", 32'(eop_cnt), 32'd3);
    check("bp_hold", 32'(hold_err), 32'd0);
    check("bp_bubble", 32'(bubble_err), 32'd0);
    check("bp_gap", 32'(gap_bad), 32'd0);
    check("bp_good", 32'(good_frames), 32'd3);
    reg_read(3'd6, rd);
    check("bp_count", rd, 32'd3);

    reg_write(3'd0, 32'd100);
    reg_write(3'd7, 32'h1);
    collect(100, 0, 64, 2, 300);
    check("stop_frames", 32'(frames), 32'd2);
    check("stop_good", 32'(good_frames), 32'd2);
    reg_read(3'd6, rd);
    check("stop_count", rd, 32'd2);
    reg_read(3'd7, rd);
    check("stop_ctrl", rd, 32'h6);
    reg_write(3'd7, 32'h0);

    reg_write(3'd0, 32'd0);
    any_wren = 1'b0;
    reg_write(3'd7, 32'h1);
    @(negedge clk);
    any_wren = any_wren | bus.tx_wren;
    check("zero_done_next", {31'h0, dut.done}, 32'h1);
    repeat (4) begin
      @(negedge clk);
      any_wren = any_wren | bus.tx_wren;
    end
    check("zero_no_wren", {31'h0, any_wren}, 32'h0);
    reg_read(3'd7, rd);
    check("zero_ctrl", rd, 32'h4);
    reg_read(3'd6, rd);
    check("zero_count", rd, 32'd0);

    reg_write(3'd0, 32'd5);
    reg_write(3'd7, 32'h1);
    bus.tx_rdy = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_active", {31'h0, bus.tx_wren}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wren", {31'h0, bus.tx_wren}, 32'h0);
    check("rst_mid_data", bus.tx_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      reg_read(3'(a), rd);
      check($sformatf("rst_mid_reg%0d", a), rd, 32'h0);
    end
    program_macs();
    reg_write(3'd0, 32'd1);
    reg_write(3'd1, 32'd64);
    reg_write(3'd7, 32'h1);
    collect(1, 0, 64, 0, 200);
    check("rst_restart_sop", {31'h0, first_sop}, 32'h1);
    check("rst_restart_good", 32'(good_frames), 32'd1);

    reg_write(3'd0, 32'd50);
    reg_write(3'd1, 32'd1514);
    reg_write(3'd7, 32'h1);
    collect(50, 0, 1514, 0, 25000);
    repeat (3) @(negedge clk);
    check("loop_timeout", 32'(timeout), 32'd0);
    check("loop_rx_ok", 32'(good_frames), 32'd50);
    check("loop_rx_error", 32'(bad_frames), 32'd0);
    check("loop_gap", 32'(gap_bad), 32'd0);
    reg_read(3'd6, rd);
    check("loop_count", rd, 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
